// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: instruction class
// enumeration, opcode constants and loader FSM state type.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_ORI  = 3'd2,
    CLS_LUI  = 3'd3,
    CLS_ANDI = 3'd4,
    CLS_BEQ  = 3'd5,
    CLS_LW   = 3'd6,
    CLS_SW   = 3'd7
  } instr_class_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // Primary opcode for an instruction class.
  function automatic logic [5:0] class_opcode(input instr_class_e c);
    case (c)
      CLS_ADDI: class_opcode = OP_ADDI;
      CLS_ORI:  class_opcode = OP_ORI;
      CLS_LUI:  class_opcode = OP_LUI;
      CLS_ANDI: class_opcode = OP_ANDI;
      CLS_BEQ:  class_opcode = OP_BEQ;
      CLS_LW:   class_opcode = OP_LW;
      CLS_SW:   class_opcode = OP_SW;
      default:  class_opcode = OP_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// instr_field_encoder: purely combinational (class, fields) -> 32-bit word.
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  instr_class_e cls_e;
  logic [4:0]   rs_eff;

  // Pack fields; LUI has no source register so its rs slot is zeroed.
  always_comb begin
    cls_e  = instr_class_e'(cls);
    rs_eff = (cls_e == CLS_LUI) ? 5'd0 : rs;
    if (cls_e == CLS_R) word = {OP_R, rs, rt, rd, shamt, funct};
    else                word = {class_opcode(cls_e), rs_eff, rt, imm};
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts encoded-field beats, encodes them and writes
// one word per beat into instruction memory one cycle later.
// Optional checksum output enabled by defining LOADER_CHECKSUM_EN.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       enc_word;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       cksum_q, cksum_d;
`else
  // No checksum state in this build.
`endif

  instr_field_encoder u_enc (
    .cls   (in_class),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .funct (in_funct),
    .imm   (in_imm),
    .word  (enc_word)
  );

  assign accept = (state_q == ST_LOAD) && in_valid;

  // Next-state and write-pipeline logic; the write register is loaded on
  // accept so the memory strobe lands exactly one cycle after the beat.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we_d       = 1'b0;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = BASE_A;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = enc_word;
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
          cksum_d = cksum_q ^ enc_word;
`endif
          if (in_last) begin
            state_d = ST_FLUSH;
          end else if (addr_q == ADDR_MAX) begin
            // Memory full with more program to come: stop taking beats.
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any write still held in the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE_A;
      count_q    <= '0;
      overflow_q <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= BASE_A;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum  = cksum_q;
`endif

endmodule
